// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-source stages.
// Provides the default visible-area dimensions, the 24-bit {r,g,b} colour
// type, the fixed 8-entry box palette and the black constant.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 479;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BLACK = 24'h000000;

    // Box colours, stepped through once per wall bounce.
    localparam rgb_t PALETTE [8] = '{
        24'hFFFFFF,   // white
        24'hFF0000,   // red
        24'h00FF00,   // green
        24'h0000FF,   // blue
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'hFF00FF,   // magenta
        24'hFF8000    // orange
    };

endpackage

// File: rtl/vga_frame_tick.sv
// Frame tick generator.
// Registers videoon and row by one cycle and raises tick_o for exactly one
// cycle after videoon falls at the end of the last visible line, so that
// per-frame updates land inside vertical blanking.
// Ports:
//   clk_i      pixel clock
//   rst_ni     asynchronous active-low reset
//   row_i      current row from pixel logic
//   videoon_i  active-video flag from pixel logic
//   tick_o     registered one-cycle frame tick
module vga_frame_tick
    import vga_pkg::*;
#(
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [8:0] row_i,
    input  logic       videoon_i,
    output logic       tick_o
);

    localparam logic [8:0] LAST_ROW = 9'(V_ACTIVE - 1);

    logic       von_d_q;
    logic [8:0] row_d_q;
    logic       tick_q;
    logic       tick_d;

    // Falling edge of videoon while the delayed row is the last visible line.
    always_comb begin
        tick_d = 1'b0;
        if (von_d_q && !videoon_i && (row_d_q == LAST_ROW)) begin
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Delay registers and the registered tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            von_d_q <= 1'b0;
            row_d_q <= 9'd0;
            tick_q  <= 1'b0;
        end else begin
            von_d_q <= videoon_i;
            row_d_q <= row_i;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_box_painter.sv
// Bouncing-box pixel source.
// Draws a solid SIZE x SIZE square over a constant background. Once per
// frame (while enable is high) the square moves STEP pixels on each axis and
// reflects off the visible-area edges; each bounce advances the box colour
// through the palette and pulses bounce for one cycle.
// Ports:
//   clk            pixel clock
//   reset          asynchronous active-low reset
//   enable         motion enable, sampled at the frame tick
//   row, column    current pixel position from pixel logic
//   videoon        active-video flag from pixel logic
//   red/green/blue registered colour channels (1-cycle latency)
//   bounce         one-cycle pulse when a wall hit is applied
module vga_box_painter
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   SIZE     = 32,
    parameter int   STEP     = 4,
    parameter rgb_t BG_RGB   = 24'h000040
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] row,
    input  logic [9:0] column,
    input  logic       videoon,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       bounce
);

    // 11-bit working widths keep x+STEP and x+SIZE from wrapping.
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(SIZE);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SIZE);
    localparam logic [9:0]  X_MAX_N = 10'(H_ACTIVE - SIZE);
    localparam logic [8:0]  Y_MAX_N = 9'(V_ACTIVE - SIZE);
    localparam logic [9:0]  STEP_X = 10'(STEP);
    localparam logic [8:0]  STEP_Y = 9'(STEP);

    logic       tick_s;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic [2:0] cidx_q;
    logic       hit_x_s, hit_y_s;
    logic       bounce_q;
    rgb_t       rgb_q, rgb_d;
    logic [10:0] x_ext_s, y_ext_s, col_ext_s, row_ext_s;
    logic       inside_s;

    vga_frame_tick #(
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_tick (
        .clk_i     (clk),
        .rst_ni    (reset),
        .row_i     (row),
        .videoon_i (videoon),
        .tick_o    (tick_s)
    );

    assign x_ext_s   = {1'b0, x_q};
    assign y_ext_s   = {2'b00, y_q};
    assign col_ext_s = {1'b0, column};
    assign row_ext_s = {2'b00, row};

    // Horizontal candidate move: clamp to the wall and reverse on a hit.
    always_comb begin
        x_d     = x_q;
        dx_d    = dx_q;
        hit_x_s = 1'b0;
        if (dx_q) begin
            if ((x_ext_s + STEP_W) > X_MAX) begin
                x_d     = X_MAX_N;
                dx_d    = 1'b0;
                hit_x_s = 1'b1;
            end else begin
                x_d = x_q + STEP_X;
            end
        end else begin
            if (x_ext_s < STEP_W) begin
                x_d     = 10'd0;
                dx_d    = 1'b1;
                hit_x_s = 1'b1;
            end else begin
                x_d = x_q - STEP_X;
            end
        end
    end

    // Vertical candidate move, same rule as the horizontal axis.
    always_comb begin
        y_d     = y_q;
        dy_d    = dy_q;
        hit_y_s = 1'b0;
        if (dy_q) begin
            if ((y_ext_s + STEP_W) > Y_MAX) begin
                y_d     = Y_MAX_N;
                dy_d    = 1'b0;
                hit_y_s = 1'b1;
            end else begin
                y_d = y_q + STEP_Y;
            end
        end else begin
            if (y_ext_s < STEP_W) begin
                y_d     = 9'd0;
                dy_d    = 1'b1;
                hit_y_s = 1'b1;
            end else begin
                y_d = y_q - STEP_Y;
            end
        end
    end

    // Motion state: commit the candidate move on an enabled frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q      <= 10'd0;
            y_q      <= 9'd0;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            cidx_q   <= 3'd0;
            bounce_q <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
            if (tick_s && enable) begin
                x_q  <= x_d;
                y_q  <= y_d;
                dx_q <= dx_d;
                dy_q <= dy_d;
                // A corner hit advances the colour only once.
                if (hit_x_s || hit_y_s) begin
                    cidx_q   <= cidx_q + 3'd1;
                    bounce_q <= 1'b1;
                end else begin
                    cidx_q <= cidx_q;
                end
            end else begin
                x_q <= x_q;
            end
        end
    end

    // Box membership for the current pixel against the registered geometry.
    assign inside_s = (col_ext_s >= x_ext_s) && (col_ext_s < (x_ext_s + SIZE_W)) &&
                      (row_ext_s >= y_ext_s) && (row_ext_s < (y_ext_s + SIZE_W));

    // Pixel colour select: blank, box colour or background.
    always_comb begin
        rgb_d = BLACK;
        if (!videoon) begin
            rgb_d = BLACK;
        end else if (inside_s) begin
            rgb_d = PALETTE[cidx_q];
        end else begin
            rgb_d = BG_RGB;
        end
    end

    // Registered colour output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red    = rgb_q[23:16];
    assign green  = rgb_q[15:8];
    assign blue   = rgb_q[7:0];
    assign bounce = bounce_q;

endmodule

// File: tb/tb_vga_box_painter.sv
// Directed bench for vga_box_painter. Frames are abbreviated to the end of
// the last visible line; box position is observed through pixel probes.
// A second, small-screen instance exercises a simultaneous corner hit.
module tb_vga_box_painter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [8:0] row;
    logic [9:0] column;
    logic       videoon;
    logic [7:0] red, green, blue;
    logic       bounce;

    logic [8:0] c_row;
    logic [9:0] c_col;
    logic       c_von;
    logic [7:0] c_red, c_green, c_blue;
    logic       c_bounce;

    int n_cmp = 0;
    int n_err = 0;
    int bnc_cnt = 0;
    int c_bnc_cnt = 0;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BG    = 24'h000040;

    vga_box_painter dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .row     (row),
        .column  (column),
        .videoon (videoon),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .bounce  (bounce)
    );

    vga_box_painter #(
        .H_ACTIVE (64),
        .V_ACTIVE (64)
    ) dut_c (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .row     (c_row),
        .column  (c_col),
        .videoon (c_von),
        .red     (c_red),
        .green   (c_green),
        .blue    (c_blue),
        .bounce  (c_bounce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bounce) bnc_cnt++;
        if (c_bounce) c_bnc_cnt++;
    endtask

    task automatic frame();
        row = 9'd478; column = 10'd0; videoon = 1'b1;
        step(); step();
        videoon = 1'b0;
        repeat (4) step();
    endtask

    task automatic c_frame();
        c_row = 9'd63; c_col = 10'd0; c_von = 1'b1;
        step(); step();
        c_von = 1'b0;
        repeat (4) step();
    endtask

    task automatic pix(input string tag, input int c, input int r, input logic [23:0] exp);
        videoon = 1'b1; row = 9'(r); column = 10'(c);
        step();
        chk(tag, {8'h00, red, green, blue}, {8'h00, exp});
    endtask

    task automatic c_pix(input string tag, input int c, input int r, input logic [23:0] exp);
        c_von = 1'b1; c_row = 9'(r); c_col = 10'(c);
        step();
        chk(tag, {8'h00, c_red, c_green, c_blue}, {8'h00, exp});
    endtask

    initial begin
        int b0;
        reset = 1'b0; enable = 1'b1;
        row = 9'd0; column = 10'd0; videoon = 1'b0;
        c_row = 9'd0; c_col = 10'd0; c_von = 1'b0;
        #1;
        chk("rst_rgb0", {8'h00, red, green, blue}, 32'h0);
        chk("rst_bnc0", {31'd0, bounce}, 32'd1 - 32'd1);
        step(); step();
        reset = 1'b1;
        pix("init_box", 0, 0, WHITE);
        pix("init_bg", 32, 0, BG);

        // Three enabled frames: box at (12,12), no bounce.
        bnc_cnt = 0;
        repeat (3) frame();
        pix("mv_left_bg", 11, 12, BG);
        pix("mv_box", 12, 12, WHITE);
        pix("mv_far", 43, 43, WHITE);
        pix("mv_right_bg", 44, 12, BG);
        pix("mv_top_bg", 12, 11, BG);
        chk("mv_nobnc", bnc_cnt, 0);

        // Reset mid-line: outputs clear at once, box back at origin.
        videoon = 1'b1; row = 9'd20; column = 10'd20;
        step();
        chk("pre_rst", {8'h00, red, green, blue}, {8'h00, WHITE});
        #2 reset = 1'b0;
        #1;
        chk("midrst_rgb", {8'h00, red, green, blue}, 32'h0);
        chk("midrst_bnc", {31'd0, bounce}, 32'h0);
        step();
        reset = 1'b1;
        pix("post_rst_box", 0, 0, WHITE);
        pix("post_rst_bg", 32, 0, BG);
        pix("post_rst_old", 43, 43, BG);

        // 151 ticks: y bounces at tick 112 (cidx 1), box at (604,291).
        bnc_cnt = 0;
        repeat (151) frame();
        chk("run_bnc", bnc_cnt, 1);
        pix("x604_box", 604, 291, RED);
        pix("x604_lbg", 603, 291, BG);
        pix("x604_tbg", 604, 290, BG);
        frame();
        chk("x608_nobnc", bnc_cnt, 1);
        pix("x608_box", 608, 287, RED);
        pix("x608_lbg", 607, 287, BG);

        // Right-wall tick with pulse timing checked cycle by cycle.
        row = 9'd478; column = 10'd0; videoon = 1'b1;
        step(); step();
        videoon = 1'b0;
        step(); chk("bnc_t1", {31'd0, bounce}, 32'd0);
        step(); chk("bnc_t2", {31'd0, bounce}, 32'd1);
        step(); chk("bnc_t3", {31'd0, bounce}, 32'd0);
        step();
        chk("wall_bnc", bnc_cnt, 2);
        pix("wall_box", 608, 283, GREEN);
        pix("wall_lbg", 607, 283, BG);
        pix("wall_edge", 639, 314, GREEN);
        frame();
        pix("back_box", 604, 279, GREEN);
        pix("back_rbg", 636, 279, BG);

        // Pause: five ticks with enable low change nothing.
        b0 = bnc_cnt;
        enable = 1'b0;
        repeat (5) frame();
        chk("pause_bnc", bnc_cnt, b0);
        pix("pause_box", 604, 279, GREEN);
        pix("pause_lbg", 603, 279, BG);
        pix("pause_tbg", 604, 278, BG);
        enable = 1'b1;
        frame();
        pix("resume_box", 600, 275, GREEN);
        pix("resume_rbg", 632, 275, BG);
        pix("resume_tbg", 600, 274, BG);

        // Blanking and a long low videoon on row 478 giving a single tick.
        videoon = 1'b0; row = 9'd300; column = 10'd610;
        step();
        chk("blank_rgb", {8'h00, red, green, blue}, 32'h0);
        row = 9'd478; column = 10'd0; videoon = 1'b1;
        step(); step();
        videoon = 1'b0;
        repeat (20) step();
        pix("one_tick_box", 596, 271, GREEN);
        pix("one_tick_lbg", 595, 271, BG);
        pix("one_tick_r", 627, 271, GREEN);
        pix("one_tick_rbg", 628, 271, BG);
        chk("one_tick_bnc", bnc_cnt, b0);
        videoon = 1'b0; row = 9'd0;
        step();

        // Small screen: both axes reach 32 together, tick 9 is a corner hit.
        c_bnc_cnt = 0;
        repeat (8) c_frame();
        chk("c_pre_bnc", c_bnc_cnt, 0);
        c_pix("c_pre_box", 32, 32, WHITE);
        c_pix("c_pre_bg", 31, 32, BG);
        c_frame();
        chk("c_corner_bnc", c_bnc_cnt, 1);
        c_pix("c_corner_box", 32, 32, RED);
        c_frame();
        c_pix("c_back_box", 28, 28, RED);
        c_pix("c_back_bg", 60, 28, BG);
        chk("c_back_bnc", c_bnc_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
